// File: rtl/usb_rx_pkg.sv
// Shared types and default timing constants for the full-speed USB RX/TX timers.
// Defaults live here so the TX and RX timers agree on bit timing.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    RUN       = 2'd2
  } rx_tmr_state_t;

  localparam int USB_CLKS_PER_BIT = 8;
  localparam int USB_SAMPLE_POINT = 3;
  localparam int USB_LONG_EVERY_3 = 1;
  localparam int USB_STUFF_RUN    = 6;

endpackage

// File: rtl/usb_edge_detect.sv
// Line transition detector: registered previous level (resets to J = 1) XORed
// with the current synchronized level. Shared with the EOP detector.
module usb_edge_detect
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic d_in,
  output logic line_edge
);

  logic d_prev_q;
  logic d_prev_d;

  assign d_prev_d  = d_in;
  assign line_edge = d_in ^ d_prev_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      d_prev_q <= 1'b1;
    end else begin
      d_prev_q <= d_prev_d;
    end
  end

endmodule

// File: rtl/usb_rx_timer.sv
// Full-speed USB RX bit timing, NRZI decode and bit unstuffing front end.
// Optional macro USB_RX_TIMER_STUFF_ERR_EN adds the stuff_err output.
module usb_rx_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT,
  parameter int SAMPLE_POINT = USB_SAMPLE_POINT,
  parameter int LONG_EVERY_3 = USB_LONG_EVERY_3,
  parameter int STUFF_RUN    = USB_STUFF_RUN
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus_sync,
  input  logic       rcving,
  output logic       d_orig,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [2:0] bit_cnt
`ifdef USB_RX_TIMER_STUFF_ERR_EN
  ,
  output logic       stuff_err
`endif
);

  localparam int PHASE_W = $clog2(CLKS_PER_BIT + 2);
  localparam int ONES_W  = $clog2(STUFF_RUN + 1);

  localparam logic [PHASE_W-1:0] SAMPLE_PH  = PHASE_W'(SAMPLE_POINT);
  localparam logic [PHASE_W-1:0] SHORT_LAST = PHASE_W'(CLKS_PER_BIT - 1);
  localparam logic [PHASE_W-1:0] LONG_LAST  = PHASE_W'(CLKS_PER_BIT);
  localparam logic [ONES_W-1:0]  ONES_MAX   = ONES_W'(STUFF_RUN);

  rx_tmr_state_t      state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [1:0]         long_cnt_q, long_cnt_d;
  logic [ONES_W-1:0]  ones_cnt_q, ones_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic               last_level_q, last_level_d;
  logic               d_orig_q, d_orig_d;
  logic               shift_enable_q, shift_enable_d;
  logic               byte_wrap_q, byte_wrap_d;
  logic               byte_received_q, byte_received_d;
`ifdef USB_RX_TIMER_STUFF_ERR_EN
  logic               stuff_err_q, stuff_err_d;
`endif

  logic               line_edge;
  logic               sample_bit;
  logic [PHASE_W-1:0] period_last;

  usb_edge_detect u_edge (
    .clk       (clk),
    .n_rst     (n_rst),
    .d_in      (d_plus_sync),
    .line_edge (line_edge)
  );

  // NRZI: a bit is 1 when the line did not change since the previous sample.
  assign sample_bit  = (d_plus_sync == last_level_q);
  assign period_last = ((LONG_EVERY_3 != 0) && (long_cnt_q == 2'd2)) ? LONG_LAST : SHORT_LAST;

  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    long_cnt_d      = long_cnt_q;
    ones_cnt_d      = ones_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    last_level_d    = last_level_q;
    d_orig_d        = d_orig_q;
    shift_enable_d  = 1'b0;
    byte_wrap_d     = 1'b0;
    byte_received_d = byte_wrap_q;
`ifdef USB_RX_TIMER_STUFF_ERR_EN
    stuff_err_d     = 1'b0;
`endif

    if (!rcving) begin
      state_d    = IDLE;
      phase_d    = '0;
      long_cnt_d = '0;
      ones_cnt_d = '0;
      bit_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = WAIT_EDGE;
          phase_d      = '0;
          long_cnt_d   = '0;
          ones_cnt_d   = '0;
          bit_cnt_d    = '0;
          last_level_d = 1'b1;
        end
        WAIT_EDGE: begin
          if (line_edge) begin
            state_d = RUN;
            phase_d = PHASE_W'(1);
          end
        end
        RUN: begin
          if (phase_q == SAMPLE_PH) begin
            last_level_d = d_plus_sync;
            if (ones_cnt_q == ONES_MAX) begin
              ones_cnt_d  = '0;
`ifdef USB_RX_TIMER_STUFF_ERR_EN
              stuff_err_d = sample_bit;
`endif
            end else begin
              d_orig_d       = sample_bit;
              shift_enable_d = 1'b1;
              ones_cnt_d     = sample_bit ? ones_cnt_q + 1'b1 : '0;
              bit_cnt_d      = bit_cnt_q + 3'd1;
              byte_wrap_d    = (bit_cnt_q == 3'd7);
            end
          end
          // An edge re-aligns the phase but keeps the 8/8/9 position.
          if (line_edge) begin
            phase_d = PHASE_W'(1);
          end else if (phase_q == period_last) begin
            phase_d    = '0;
            long_cnt_d = (long_cnt_q == 2'd2) ? 2'd0 : long_cnt_q + 2'd1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      phase_q         <= '0;
      long_cnt_q      <= '0;
      ones_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      last_level_q    <= 1'b1;
      d_orig_q        <= 1'b1;
      shift_enable_q  <= 1'b0;
      byte_wrap_q     <= 1'b0;
      byte_received_q <= 1'b0;
`ifdef USB_RX_TIMER_STUFF_ERR_EN
      stuff_err_q     <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      long_cnt_q      <= long_cnt_d;
      ones_cnt_q      <= ones_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      last_level_q    <= last_level_d;
      d_orig_q        <= d_orig_d;
      shift_enable_q  <= shift_enable_d;
      byte_wrap_q     <= byte_wrap_d;
      byte_received_q <= byte_received_d;
`ifdef USB_RX_TIMER_STUFF_ERR_EN
      stuff_err_q     <= stuff_err_d;
`endif
    end
  end

  assign d_orig        = d_orig_q;
  assign shift_enable  = shift_enable_q;
  assign byte_received = byte_received_q;
  assign bit_cnt       = bit_cnt_q;
`ifdef USB_RX_TIMER_STUFF_ERR_EN
  assign stuff_err     = stuff_err_q;
`endif

endmodule

// File: tb/tb_usb_rx_timer.sv
// Self-checking bench for usb_rx_timer: timestamp-based reference model, directed
// SYNC/stuffing/jitter/abort scenarios and randomized NRZI packets.
module tb_usb_rx_timer;

  localparam int CPB   = 8;
  localparam int SP    = 3;
  localparam int STUFF = 6;
  localparam int LONG3 = 1;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_plus_sync = 1'b1;
  logic       rcving = 1'b0;
  logic       d_orig;
  logic       shift_enable;
  logic       byte_received;
  logic [2:0] bit_cnt;
`ifdef USB_RX_TIMER_STUFF_ERR_EN
  logic       stuff_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  usb_rx_timer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .d_plus_sync   (d_plus_sync),
    .rcving        (rcving),
    .d_orig        (d_orig),
    .shift_enable  (shift_enable),
    .byte_received (byte_received),
    .bit_cnt       (bit_cnt)
`ifdef USB_RX_TIMER_STUFF_ERR_EN
    ,
    .stuff_err     (stuff_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state: bit periods tracked as start timestamps, not a phase counter.
  int   cyc = 0;
  int   last_edge_cyc = 0;
  logic prev_d = 1'b1;
  logic in_pkt = 1'b0;
  logic locked = 1'b0;
  int   t0 = 0;
  int   nper = 0;
  int   ones = 0;
  int   nbits = 0;
  logic last = 1'b1;
  logic wrap_pend = 1'b0;
  logic m_dorig = 1'b1;
  logic m_shift = 1'b0;
  logic m_byte = 1'b0;
  logic m_err = 1'b0;
  int   pos, len;
  logic b, edge_now;

  // Observation log used by the directed scenarios.
  int   shift_t[$];
  logic shift_b[$];
  int   lag_q[$];
  int   n_byte = 0;
  int   n_err = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge n_rst);
    if (!n_rst) begin
      prev_d = 1'b1; in_pkt = 1'b0; locked = 1'b0; t0 = 0; nper = 0; ones = 0;
      nbits = 0; last = 1'b1; wrap_pend = 1'b0; m_dorig = 1'b1; m_shift = 1'b0;
      m_byte = 1'b0; m_err = 1'b0;
    end else begin
      cyc++;
      edge_now = (d_plus_sync != prev_d);
      prev_d = d_plus_sync;
      if (edge_now) last_edge_cyc = cyc;
      m_byte = wrap_pend;
      wrap_pend = 1'b0;
      m_shift = 1'b0;
      m_err = 1'b0;
      if (!rcving) begin
        in_pkt = 1'b0; locked = 1'b0; ones = 0; nbits = 0; nper = 0;
      end else if (!in_pkt) begin
        in_pkt = 1'b1; locked = 1'b0; ones = 0; nbits = 0; nper = 0; last = 1'b1;
      end else if (!locked) begin
        if (edge_now) begin
          locked = 1'b1; t0 = cyc; nper = 0;
        end
      end else begin
        pos = cyc - t0;
        len = CPB + ((LONG3 != 0 && (nper % 3) == 2) ? 1 : 0);
        if (pos == SP) begin
          b = (d_plus_sync == last);
          last = d_plus_sync;
          if (ones == STUFF) begin
            ones = 0;
            m_err = b;
          end else begin
            m_dorig = b;
            m_shift = 1'b1;
            ones = b ? ones + 1 : 0;
            if (nbits == 7) wrap_pend = 1'b1;
            nbits = (nbits + 1) % 8;
          end
        end
        if (edge_now) t0 = cyc;
        else if (pos == len - 1) begin
          t0 = cyc + 1;
          nper++;
        end
      end
    end
  end

  // Every-cycle compare, 1 time unit after the active edge.
  initial forever begin
    @(posedge clk);
    #1;
    checkOutput("shift_enable", shift_enable, m_shift);
    checkOutput("byte_received", byte_received, m_byte);
    checkOutput("bit_cnt", bit_cnt, nbits);
    checkOutput("d_orig", d_orig, m_dorig);
`ifdef USB_RX_TIMER_STUFF_ERR_EN
    checkOutput("stuff_err", stuff_err, m_err);
    if (stuff_err) n_err++;
`endif
    if (shift_enable) begin
      shift_t.push_back(cyc);
      shift_b.push_back(d_orig);
      lag_q.push_back(cyc - last_edge_cyc);
    end
    if (byte_received) n_byte++;
  end

  // Called at a falling edge; holds the given inputs for clks cycles.
  task automatic applyStimulus(input logic lvl, input logic rcv, input int clks);
    d_plus_sync = lvl;
    rcving = rcv;
    repeat (clks) @(negedge clk);
  endtask

  task automatic clearLog();
    shift_t.delete();
    shift_b.delete();
    lag_q.delete();
    n_byte = 0;
    n_err = 0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_d_orig"}, d_orig, 1);
    checkOutput({tag, "_shift_enable"}, shift_enable, 0);
    checkOutput({tag, "_byte_received"}, byte_received, 0);
    checkOutput({tag, "_bit_cnt"}, bit_cnt, 0);
`ifdef USB_RX_TIMER_STUFF_ERR_EN
    checkOutput({tag, "_stuff_err"}, stuff_err, 0);
`endif
  endtask

  task automatic applyReset();
    #2 n_rst = 1'b0;
    #1 checkResetValues("async_rst");
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Random packet: SYNC + random bytes, NRZI encoded with stuffing (sometimes a bad stuff bit).
  task automatic sendPacket(input int nbytes, input int rst_at, input int drop_at, input bit jitter);
    logic q[$];
    int   run = 0;
    int   bp = 0;
    int   dur;
    logic lvl = 1'b1;
    logic [7:0] by;
    for (int i = 0; i < 7; i++) q.push_back(1'b0);
    q.push_back(1'b1);
    run = 1;
    for (int n = 0; n < nbytes; n++) begin
      by = 8'($urandom);
      for (int j = 0; j < 8; j++) begin
        q.push_back(by[j]);
        run = by[j] ? run + 1 : 0;
        if (run == STUFF) begin
          q.push_back($urandom_range(0, 5) == 0);
          run = 0;
        end
      end
    end
    applyStimulus(1'b1, 1'b1, 2 + $urandom_range(0, 3));
    for (int i = 0; i < q.size(); i++) begin
      if (i == rst_at) applyReset();
      if (i == drop_at) break;
      if (!q[i]) lvl = ~lvl;
      dur = CPB + ((bp % 3 == 2) ? 1 : 0);
      bp++;
      if (jitter && $urandom_range(0, 3) == 0) dur += ($urandom_range(0, 1) != 0) ? 1 : -1;
      applyStimulus(lvl, 1'b1, dur);
    end
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 4);
  endtask

  initial begin
    int v;
    logic lvl;

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    n_rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 2);

    // SYNC KJKJKJKK: seven 0s then a 1, one byte
    applyStimulus(1'b1, 1'b1, 3);
    clearLog();
    for (int i = 0; i < 7; i++) applyStimulus((i % 2 == 0) ? 1'b0 : 1'b1, 1'b1, (i == 6) ? 16 : 8);
    checkOutput("sync_nshift", shift_t.size(), 8);
    checkOutput("sync_nbyte", n_byte, 1);
    checkOutput("sync_bitcnt", bit_cnt, 0);
    if (shift_t.size() == 8) begin
      v = 0;
      for (int i = 0; i < 8; i++) v |= int'(shift_b[i]) << i;
      checkOutput("sync_byte", v, 128);
      for (int i = 1; i < 7; i++) checkOutput("sync_spacing", shift_t[i] - shift_t[i-1], 8);
      checkOutput("sync_last_spacing", shift_t[7] - shift_t[6], 9);
    end
    applyStimulus(1'b1, 1'b0, 4);

    // Transition then six 1s, then a proper stuff transition
    applyStimulus(1'b1, 1'b1, 3);
    clearLog();
    applyStimulus(1'b0, 1'b1, 58);
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("stuff_ok_nshift", shift_t.size(), 7);
    checkOutput("stuff_ok_bitcnt", bit_cnt, 7);
`ifdef USB_RX_TIMER_STUFF_ERR_EN
    checkOutput("stuff_ok_nerr", n_err, 0);
`endif
    if (shift_t.size() == 7) begin
      v = 0;
      for (int i = 0; i < 7; i++) v |= int'(shift_b[i]) << i;
      checkOutput("stuff_ok_bits", v, 126);
      for (int i = 1; i < 7; i++)
        checkOutput("long3_spacing", shift_t[i] - shift_t[i-1], (i % 3 == 0) ? 9 : 8);
    end
    applyStimulus(1'b1, 1'b0, 4);

    // Same, but the stuff bit has no transition
    applyStimulus(1'b1, 1'b1, 3);
    clearLog();
    applyStimulus(1'b0, 1'b1, 66);
    checkOutput("stuff_bad_nshift", shift_t.size(), 7);
    checkOutput("stuff_bad_bitcnt", bit_cnt, 7);
`ifdef USB_RX_TIMER_STUFF_ERR_EN
    checkOutput("stuff_bad_nerr", n_err, 1);
`endif
    applyStimulus(1'b0, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 3);

    // Edges jittered 7/9 clocks apart: each sample SP clocks after the latest edge
    applyStimulus(1'b1, 1'b1, 3);
    clearLog();
    lvl = 1'b1;
    for (int i = 0; i < 12; i++) begin
      lvl = ~lvl;
      applyStimulus(lvl, 1'b1, (i == 11) ? 6 : (($urandom_range(0, 1) != 0) ? 9 : 7));
    end
    checkOutput("jitter_nshift", shift_t.size(), 12);
    foreach (lag_q[i]) checkOutput("jitter_lag", lag_q[i], SP);
    applyStimulus(1'b1, 1'b0, 4);

    // Abort after five bits, then a fresh byte counts from zero
    applyStimulus(1'b1, 1'b1, 3);
    clearLog();
    lvl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lvl = ~lvl;
      applyStimulus(lvl, 1'b1, (i == 4) ? 5 : 8);
    end
    applyStimulus(lvl, 1'b0, 4);
    checkOutput("abort_nshift", shift_t.size(), 5);
    checkOutput("abort_bitcnt", bit_cnt, 0);
    checkOutput("abort_nbyte", n_byte, 0);
    applyStimulus(lvl, 1'b1, 3);
    clearLog();
    for (int i = 0; i < 8; i++) begin
      lvl = ~lvl;
      applyStimulus(lvl, 1'b1, 8);
    end
    checkOutput("restart_nshift", shift_t.size(), 8);
    checkOutput("restart_nbyte", n_byte, 1);
    checkOutput("restart_bitcnt", bit_cnt, 0);
    applyStimulus(lvl, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 3);

    // Randomized packets, one with an async reset and some aborted early
    for (int p = 0; p < 24; p++) begin
      sendPacket($urandom_range(1, 4), (p == 7) ? 20 : -1,
                 (p % 5 == 3) ? $urandom_range(10, 30) : -1, p[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_rx_timer.md
Name: usb_rx_timer

Overview:
Receive-side bit timing and NRZI/unstuff front end for the full-speed USB endpoint. It pairs with the TX timer, which generates bit strobes for the transmitter.
- Recovers bit timing from synchronized D+ by re-aligning its phase counter on every line transition.
- Samples mid-bit, NRZI-decodes, and drops stuffed bits.
- Produces shift_enable and byte_received strobes for the RX shift register and RX control FSM.

Parameters:
CLKS_PER_BIT, 8, nominal system clocks per USB bit
SAMPLE_POINT, 3, phase value (0 = edge cycle) at which the line is sampled; must be < CLKS_PER_BIT
LONG_EVERY_3, 1, when 1 every third bit period is CLKS_PER_BIT+1 clocks (8/8/9 pattern, matches TX)
STUFF_RUN, 6, consecutive decoded 1s after which the next bit is a stuff bit

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
d_plus_sync  in  1  D+ after 2-flop synchronizer
rcving  in  1  high while RX FSM is inside a packet; low forces idle
d_orig  out  1  registered NRZI-decoded data bit, valid when shift_enable
shift_enable  out  1  one-cycle pulse: a data (non-stuff) bit is ready on d_orig
byte_received  out  1  one-cycle pulse one clock after the 8th shift_enable of a byte
bit_cnt  out  3  data bits accepted in current byte (0..7)

Behaviour:
- Reset values:
  - State IDLE; phase, long_cnt, ones_cnt, bit_cnt = 0.
  - d_prev (edge detect) = 1; last_level = 1 (J).
  - d_orig = 1; shift_enable = 0; byte_received = 0.
- Edge detect: edge = d_plus_sync ^ d_prev; d_prev registered every cycle, in all states.
- FSM states: IDLE, WAIT_EDGE, RUN.
  - IDLE -> WAIT_EDGE: when rcving=1. On entry, clear counters and set last_level=1.
  - WAIT_EDGE -> RUN: on the first edge. Phase loads 1, so the edge cycle counts as phase 0.
  - Any state -> IDLE: when rcving=0, next cycle. No shift_enable is issued in a cycle with rcving=0. All counters are cleared.
- Phase counter (RUN):
  - Increments each cycle and wraps to 0 at period-1.
  - period = CLKS_PER_BIT+1 when LONG_EVERY_3=1 and long_cnt==2; otherwise period = CLKS_PER_BIT.
  - long_cnt counts 0,1,2 per wrap.
- Edge in RUN: phase loads 1 regardless of current phase; long_cnt is unchanged. An edge arriving in the same cycle as a sample point still samples, using the pre-edge phase match.
- Sample (RUN, phase==SAMPLE_POINT, rcving=1):
  - bit = (d_plus_sync == last_level); then last_level <= d_plus_sync.
  - If ones_cnt == STUFF_RUN: stuff bit.
    - No shift_enable; ones_cnt <= 0.
    - bit_cnt and d_orig are unchanged.
  - Otherwise: data bit.
    - d_orig <= bit; shift_enable pulses next cycle (registered, aligned with d_orig).
    - ones_cnt <= bit ? ones_cnt+1 : 0.
    - bit_cnt increments modulo 8.
- byte_received: asserted the cycle after the shift_enable whose accept wrapped bit_cnt 7->0. It still fires if rcving falls in that cycle.
- ones_cnt saturates conceptually at STUFF_RUN; it never exceeds it.
- Async reset mid-packet returns to the reset values immediately.

Optional Feature:
Macro USB_RX_TIMER_STUFF_ERR_EN.
- Defined: adds output port stuff_err (1 bit, reset 0). It pulses one cycle, aligned with where shift_enable would be, when a stuff-bit sample decodes as 1 (no transition). The timer continues running.
- Undefined: no port, no check logic; the stuff bit is discarded silently.

Decomposition:
- Shared package usb_rx_pkg:
  - state enum rx_tmr_state_t {IDLE, WAIT_EDGE, RUN}
  - localparams for default CLKS_PER_BIT, SAMPLE_POINT, STUFF_RUN, shared with the TX timer
- Sub-module usb_edge_detect (d_prev register plus XOR, reset-high prev) is natural and reusable by the EOP detector.
- Phase/bit counting stays inline.

Test Plan:
- Reset, then rcving=1 and SYNC pattern (alternating levels every 8 clks from J) -> first edge enters RUN; shift_enable with d_orig=0 for 7 bits; a pattern ending KK yields d_orig=1 on the 8th; byte_received 1 clk after the 8th shift_enable, with bit_cnt back to 0.
- Constant line for 7 bit-times after a transition (decoded 0 then six 1s, then forced transition) -> six shift_enables of 1; the 7th sample produces no shift_enable; with the macro defined, stuff_err=0.
- Same as above but no transition on the stuff bit -> stuff_err pulses once (macro on); no shift_enable; ones_cnt=0.
- Edges jittered to 7 and 9 clks apart -> every sample occurs exactly SAMPLE_POINT clks after the latest edge; no missed or duplicate shift_enable.
- Long run of 1s without edges, LONG_EVERY_3=1 -> sample spacing 8,8,9 clocks repeating.
- rcving dropped after bit 5 -> next cycle IDLE, bit_cnt=0, no byte_received; reassert plus new edge -> byte counts from 0.
